// File: rtl/xsim_portal_pkg.sv
// Shared types and the host endpoint for the xsim portal bridge.
//   - method ids, the request/response header layout, the FSM state enum
//   - dpi_msgSink_beat / dpi_msgSource_beat: the SystemVerilog side of the
//     host mailbox. The request stream is a table filled by the host side
//     (xs_sink_*); every response beat is logged with its edge stamp
//     (xs_src_*). xs_cyc is advanced once per posedge by the host side.
package xsim_portal_pkg;

  localparam logic [15:0] METHOD_ECHO  = 16'd0;
  localparam logic [15:0] METHOD_SUM   = 16'd1;
  localparam logic [15:0] METHOD_COUNT = 16'd2;

  typedef struct packed {
    logic [15:0] method;
    logic [15:0] len;
  } hdr_t;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_SEND_HDR, ST_SEND_DATA} state_t;

  function automatic logic method_ok(logic [15:0] m);
    return (m == METHOD_ECHO) || (m == METHOD_SUM) || (m == METHOD_COUNT);
  endfunction

  // Host mailbox state.
  int          xs_cyc;
  logic [31:0] xs_sink_beat [0:255];
  logic        xs_sink_rdy  [0:255];
  logic [7:0]  xs_sink_wr;
  logic [7:0]  xs_sink_rd;
  int          xs_sink_calls;
  int          xs_sink_port;
  int          xs_last_acc;
  logic [31:0] xs_src_beat  [0:255];
  int          xs_src_cyc   [0:255];
  int          xs_src_port  [0:255];
  logic [7:0]  xs_src_n;

  // An empty table or a stored src_rdy=0 entry both mean "no beat this poll".
  function automatic void dpi_msgSink_beat(input int portal, output int beat, output int src_rdy);
    xs_sink_calls = xs_sink_calls + 1;
    xs_sink_port  = portal;
    beat    = 0;
    src_rdy = 0;
    if (xs_sink_rd != xs_sink_wr) begin
      beat    = int'(xs_sink_beat[xs_sink_rd]);
      src_rdy = xs_sink_rdy[xs_sink_rd] ? 1 : 0;
      if (xs_sink_rdy[xs_sink_rd]) xs_last_acc = xs_cyc;
      xs_sink_rd = xs_sink_rd + 8'd1;
    end
  endfunction

  function automatic void dpi_msgSource_beat(input int portal, input int beat);
    xs_src_beat[xs_src_n] = 32'(beat);
    xs_src_cyc[xs_src_n]  = xs_cyc;
    xs_src_port[xs_src_n] = portal;
    xs_src_n = xs_src_n + 8'd1;
  endfunction

endpackage

// File: rtl/mk_xsim_top_portal_dpi_io.sv
// portal_dpi_io: the only place the host calls are made.
//   CLK, RST      clock, synchronous active-low reset (no calls while low)
//   deq_en        poll the request sink on this edge
//   beat_out      beat returned by the last poll
//   rdy_out       1 when the last poll returned a beat
//   enq_en        push enq_beat to the indication source on this edge
module portal_dpi_io
  import xsim_portal_pkg::*;
#(
  parameter int REQ_PORTAL = 0,
  parameter int IND_PORTAL = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        deq_en,
  output logic [31:0] beat_out,
  output logic        rdy_out,
  input  logic        enq_en,
  input  logic [31:0] enq_beat
);

  logic [31:0] beat_q;
  logic        rdy_q;

  function automatic logic [32:0] poll_sink();
    int b, r;
    dpi_msgSink_beat(REQ_PORTAL, b, r);
    return {r[0], b};
  endfunction

  // The beat is held for one cycle; the top absorbs it combinationally
  // before deciding what the next edge does.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      beat_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      if (deq_en) {rdy_q, beat_q} <= poll_sink();
      else        rdy_q <= 1'b0;
      if (enq_en) dpi_msgSource_beat(IND_PORTAL, int'(enq_beat));
    end
  end

  assign beat_out = beat_q;
  assign rdy_out  = rdy_q;

endmodule

// File: rtl/mk_xsim_top.sv
// mk_xsim_top: xsim portal bridge. Reads request messages from the request
// portal, runs echo / sum / getCount and writes the response to the
// indication portal. No wire outputs; behaviour is the sequence of host calls.
//   CLK  clock
//   RST  synchronous active-low reset
module mk_xsim_top
  import xsim_portal_pkg::*;
#(
  parameter int REQ_PORTAL = 0,
  parameter int IND_PORTAL = 1,
  parameter int MAX_BEATS  = 16
) (
  input logic CLK,
  input logic RST
);

  localparam int          IW    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [15:0] MAX16 = 16'(MAX_BEATS);

  logic [31:0] beat_in;
  logic        rdy_in;
  logic        deq_en, enq_en;
  logic [31:0] enq_beat;
  hdr_t        req_hdr;

  state_t      state_q, state_d, cur;
  logic [15:0] method_q, method_d, len_q, len_d, idx_q, idx_d, sidx_q, sidx_d;
  logic [31:0] sum_q, sum_d, ok_q, ok_d, err_q, err_d;
  logic [31:0] buf_q [MAX_BEATS];
  logic        wr_en;
  logic [15:0] rlen;
  logic [31:0] data_beat;

  portal_dpi_io #(.REQ_PORTAL(REQ_PORTAL), .IND_PORTAL(IND_PORTAL)) u_io (
    .CLK(CLK), .RST(RST),
    .deq_en(deq_en), .beat_out(beat_in), .rdy_out(rdy_in),
    .enq_en(enq_en), .enq_beat(enq_beat)
  );

  assign req_hdr = beat_in;

  // Absorb the beat fetched on the previous edge; cur is the state the
  // next edge acts in.
  always_comb begin
    cur      = state_q;
    method_d = method_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    ok_d     = ok_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    if (rdy_in && state_q == ST_IDLE) begin
      method_d = req_hdr.method;
      len_d    = req_hdr.len;
      idx_d    = '0;
      sum_d    = '0;
      if (req_hdr.len != 16'd0)          cur = ST_RECV;
      else if (method_ok(req_hdr.method)) begin cur = ST_SEND_HDR; ok_d = ok_q + 32'd1; end
      else                                err_d = err_q + 32'd1;
    end else if (rdy_in && state_q == ST_RECV) begin
      wr_en = (idx_q < MAX16);
      sum_d = sum_q + beat_in;
      idx_d = idx_q + 16'd1;
      if (idx_d == len_q) begin
        if (method_ok(method_q)) begin cur = ST_SEND_HDR; ok_d = ok_q + 32'd1; end
        else                     begin cur = ST_IDLE;     err_d = err_q + 32'd1; end
      end
    end
  end

  always_comb begin
    case (method_d)
      METHOD_ECHO: rlen = (len_d > MAX16) ? MAX16 : len_d;
      METHOD_SUM:  rlen = 16'd1;
      default:     rlen = 16'd2;
    endcase
    case (method_q)
      METHOD_ECHO: data_beat = buf_q[sidx_q[IW-1:0]];
      METHOD_SUM:  data_beat = sum_q;
      default:     data_beat = (sidx_q == 16'd0) ? ok_q : err_q;
    endcase
  end

  always_comb begin
    state_d  = cur;
    sidx_d   = sidx_q;
    deq_en   = 1'b0;
    enq_en   = 1'b0;
    enq_beat = '0;
    case (cur)
      ST_SEND_HDR: begin
        enq_en   = 1'b1;
        enq_beat = {method_d, rlen};
        sidx_d   = '0;
        state_d  = (rlen != 16'd0) ? ST_SEND_DATA : ST_IDLE;
      end
      ST_SEND_DATA: begin
        enq_en   = 1'b1;
        enq_beat = data_beat;
        sidx_d   = sidx_q + 16'd1;
        if (sidx_d == rlen) state_d = ST_IDLE;
      end
      default: deq_en = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      method_q <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      sidx_q   <= '0;
      sum_q    <= '0;
      ok_q     <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      method_q <= method_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      sidx_q   <= sidx_d;
      sum_q    <= sum_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      if (wr_en) buf_q[idx_q[IW-1:0]] <= beat_in;
    end
  end

endmodule

// File: tb/tb_mk_xsim_top.sv
module tb_mk_xsim_top;
  import xsim_portal_pkg::*;

  logic CLK, RST;
  int   n_cmp, n_bad;
  logic [31:0] exp_q[$];

  mk_xsim_top #(.REQ_PORTAL(0), .IND_PORTAL(1), .MAX_BEATS(16)) dut (.CLK(CLK), .RST(RST));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) xs_cyc <= xs_cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] b, input logic rdy);
    xs_sink_beat[xs_sink_wr] = b;
    xs_sink_rdy[xs_sink_wr]  = rdy;
    xs_sink_wr = xs_sink_wr + 8'd1;
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (xs_sink_rd != xs_sink_wr && k < 300) begin @(negedge CLK); k++; end
    if (xs_sink_rd != xs_sink_wr) chk({tag, "_drain"}, 32'(xs_sink_rd), 32'(xs_sink_wr));
  endtask

  // Checks the response in exp_q: values, indication portal, header one edge
  // after the last accepted beat, no gaps, nothing extra afterwards.
  task automatic check_resp(input string tag, input logic [7:0] base);
    int k = 0;
    logic [7:0] want, j;
    want = base + 8'(exp_q.size());
    while (xs_src_n != want && k < 300) begin @(negedge CLK); k++; end
    if (xs_src_n != want) chk({tag, "_timeout"}, 32'(xs_src_n), 32'(want));
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        j = base + 8'(i);
        chk($sformatf("%s_beat%0d", tag, i), xs_src_beat[j], exp_q[i]);
        chk($sformatf("%s_edge%0d", tag, i), 32'(xs_src_cyc[j]), 32'(xs_last_acc + 1 + i));
      end
      chk({tag, "_port"}, 32'(xs_src_port[base]), 32'd1);
      repeat (4) @(negedge CLK);
      chk({tag, "_count"}, 32'(xs_src_n), 32'(want));
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    logic [7:0] base;
    int calls;
    n_cmp = 0; n_bad = 0;
    xs_cyc = 0; xs_sink_wr = '0; xs_sink_rd = '0; xs_sink_calls = 0;
    xs_src_n = '0; xs_last_acc = 0; xs_sink_port = -1;
    RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_no_poll", 32'(xs_sink_calls), 32'd0);
    chk("rst_no_src", 32'(xs_src_n), 32'd0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("poll_start", 32'(xs_sink_calls), 32'd2);
    chk("req_port", 32'(xs_sink_port), 32'd0);

    // echo
    base = xs_src_n;
    push(32'h0000_0003, 1'b1); push(32'hA, 1'b1); push(32'hB, 1'b1); push(32'hC, 1'b1);
    exp_q = '{32'h0000_0003, 32'hA, 32'hB, 32'hC};
    check_resp("echo", base);

    // echo with L=0: header only
    base = xs_src_n;
    push(32'h0000_0000, 1'b1);
    exp_q = '{32'h0000_0000};
    check_resp("echo0", base);

    // sum wrapping
    base = xs_src_n;
    push(32'h0001_0002, 1'b1); push(32'hFFFF_FFFF, 1'b1); push(32'h2, 1'b1);
    exp_q = '{32'h0001_0001, 32'h0000_0001};
    check_resp("sumwrap", base);

    // invalid method, then getCount on fresh counters
    do_reset();
    base = xs_src_n;
    push(32'h0007_0001, 1'b1); push(32'h5, 1'b1);
    wait_drain("bad");
    repeat (5) @(negedge CLK);
    chk("bad_no_resp", 32'(xs_src_n), 32'(base));
    push(32'h0002_0000, 1'b1);
    exp_q = '{32'h0002_0002, 32'h1, 32'h1};
    check_resp("count1", base);

    // echo overflow: 20 in, 16 back
    base = xs_src_n;
    push(32'h0000_0014, 1'b1);
    for (int i = 0; i < 20; i++) push(32'h100 + 32'(i), 1'b1);
    exp_q = '{32'h0000_0010};
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h100 + 32'(i));
    check_resp("ovf", base);

    // reset mid-message
    base = xs_src_n;
    push(32'h0000_0004, 1'b1); push(32'h1, 1'b1); push(32'h2, 1'b1);
    wait_drain("mid");
    RST = 1'b0;
    calls = xs_sink_calls;
    repeat (3) @(negedge CLK);
    chk("mid_no_poll", 32'(xs_sink_calls), 32'(calls));
    chk("mid_no_src", 32'(xs_src_n), 32'(base));
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("mid_abandon", 32'(xs_src_n), 32'(base));
    push(32'h0002_0000, 1'b1);
    exp_q = '{32'h0002_0002, 32'h1, 32'h0};
    check_resp("count2", base);

    // sum with idle polls between beats
    base = xs_src_n;
    push(32'h0001_0003, 1'b1); push(32'h0, 1'b0);
    push(32'h10, 1'b1); push(32'h0, 1'b0);
    push(32'h20, 1'b1); push(32'h0, 1'b0);
    push(32'h30, 1'b1);
    exp_q = '{32'h0001_0001, 32'h60};
    check_resp("sumgap", base);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mk_xsim_top.md
# mk_xsim_top

Simulation-only top-level hardware for the xsim portal bridge. It polls host-to-hardware request beats from a DPI message sink on the request portal and decodes each message. It executes one of three methods and emits the response message as beats through a DPI message source on the indication portal. It has no wire outputs; all observable behaviour is the sequence of DPI calls.

## Interface
- REQ_PORTAL, default 0: portal number passed to `dpi_msgSink_beat`.
- IND_PORTAL, default 1: portal number passed to `dpi_msgSource_beat`.
- MAX_BEATS, default 16: payload buffer depth in 32-bit words.
- CLK  input  1  clock; all activity on posedge.
- RST  input  1  reset RST, synchronous, active-low; clock CLK.
- DPI imports used:
  - `dpi_msgSink_beat(int portal, output int beat, output int src_rdy)`
  - `dpi_msgSource_beat(int portal, int beat)`

## Operation
- Message format, both directions:
  - Header beat: [31:16] = methodId, [15:0] = payload length L in beats.
  - Followed by L payload beats.
- Sink poll: one `dpi_msgSink_beat(REQ_PORTAL, …)` call per posedge, only in IDLE or RECV. A returned src_rdy=1 means the beat is consumed. A returned src_rdy=0 means no beat; state is unchanged.
- Methods:
  - 0 echo: response header {16'd0, min(L,MAX_BEATS)}, then the stored payload words in order. Beats beyond MAX_BEATS are consumed and dropped.
  - 1 sum: response header {16'd1, 16'd1}, then one beat holding the 32-bit wrap-around sum of all L payload words (0 if L=0).
  - 2 getCount: response header {16'd2, 16'd2}, then ok_count, then err_count. Payload is consumed and ignored.
  - Any other methodId: consume L payload beats, no response, err_count += 1.
- Counters: ok_count increments when a valid-method message's last beat is received, so getCount's reported ok_count includes itself. Both counters are 32-bit and wrap.
- FSM states: IDLE, RECV, SEND_HDR, SEND_DATA.
  - IDLE: on header, latch methodId and L. Go to RECV if L>0. If L=0, go to SEND_HDR (valid method) or stay IDLE (invalid method, err_count++).
  - RECV: on the last beat, go to SEND_HDR (valid) or IDLE (invalid).
  - SEND_HDR: go to SEND_DATA if the response length is >0, else IDLE.
  - SEND_DATA: go to IDLE after the last response beat.
- No sink polling in the SEND states.

## Timing
- During RST=0: no DPI calls; state IDLE; counters, buffer index and sum cleared.
- Reset mid-message: the partial message is abandoned; no response is sent.
- Polling starts on the first posedge after RST is sampled 1.
- Last request beat accepted at edge N:
  - response header `dpi_msgSource_beat` call at edge N+1;
  - response payload beats at N+2, N+3, … with no gaps;
  - IDLE polling resumes on the edge after the last response beat.
- Header with L=0 at edge N (valid method): response header at N+1.
- Back-to-back requests: at most one beat is accepted per cycle; no bubbles are inserted in RECV.

## Structure
- Shared package xsim_portal_pkg holds:
  - method constants METHOD_ECHO=0, METHOD_SUM=1, METHOD_COUNT=2;
  - a packed header typedef {method[15:0], len[15:0]};
  - the state enum.
- One natural sub-module, portal_dpi_io, wraps both DPI calls:
  - deq_en in → beat_out / rdy_out;
  - enq_en / enq_beat in → source call.

## Test plan
- Echo: header 0x0000_0003, payload 0xA, 0xB, 0xC → source calls 0x0000_0003, 0xA, 0xB, 0xC on consecutive edges starting the edge after 0xC is accepted.
- Sum with wrap: header 0x0001_0002, payload 0xFFFF_FFFF, 0x2 → 0x0001_0001, 0x0000_0001.
- Invalid method then getCount: header 0x0007_0001, payload 0x5 → no source call. Then header 0x0002_0000 → 0x0002_0002, 0x1, 0x1.
- Echo overflow: header 0x0000_0014 with 20 payload beats → response header 0x0000_0010, then the first 16 words.
- Reset mid-message: header 0x0000_0004 plus 2 beats, then RST=0 for 3 cycles → no DPI calls during reset, no response. Then getCount → 0x0002_0002, 0x1, 0x0.
- Gaps in input: src_rdy=0 on alternate cycles during a sum of 3 beats → correct sum; header emitted exactly one edge after the last beat.
